// File: rtl/alu_reservation_station_if.sv
// Dispatch, wakeup and issue bundle for the ALU reservation station.
// rs_data packing: [21] valid, [20:14] pd, [13:7] pr2, [6:0] pr1.
interface alu_reservation_station_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3
);
  logic                          flush;
  logic                          disp_valid;
  logic                          disp_ready;
  logic [21:0]                   disp_data;
  logic                          disp_pr1_rdy;
  logic                          disp_pr2_rdy;
  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB-1:0][6:0]        wb_tag;
  logic                          fu_ready;
  logic                          alu_issued;
  logic [21:0]                   alu_rs_data;
  logic [$clog2(DEPTH):0]        occupancy;

  modport master (
    output flush, disp_valid, disp_data, disp_pr1_rdy, disp_pr2_rdy,
           wb_valid, wb_tag, fu_ready,
    input  disp_ready, alu_issued, alu_rs_data, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_data, disp_pr1_rdy, disp_pr2_rdy,
           wb_valid, wb_tag, fu_ready,
    output disp_ready, alu_issued, alu_rs_data, occupancy
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ops until both sources are ready, issues one per cycle.
// Optional RS_AGE_SELECT_EN: oldest-ready select via an age matrix; otherwise lowest-index ready.
module alu_reservation_station #(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_reservation_station_if.slave rs
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0] ent_valid, ent_rdy1, ent_rdy2;
  logic [6:0]       ent_pr1 [DEPTH];
  logic [6:0]       ent_pr2 [DEPTH];
  logic [6:0]       ent_pd  [DEPTH];
  logic [CW-1:0]    count;
  logic             issued_q;
  logic [21:0]      issue_data_q;

  logic [6:0]       disp_pr1, disp_pr2, disp_pd;
  logic             unused_disp_valid_bit;
  logic [DEPTH-1:0] wake1, wake2, cand;
  logic             byp1, byp2;
  logic [IW-1:0]    free_idx, win;
  logic             win_found, issue, accept;

  assign disp_pr1 = rs.disp_data[6:0];
  assign disp_pr2 = rs.disp_data[13:7];
  assign disp_pd  = rs.disp_data[20:14];
  assign unused_disp_valid_bit = rs.disp_data[21];

  assign rs.disp_ready  = (count != CW'(DEPTH));
  assign rs.occupancy   = count;
  assign rs.alu_issued  = issued_q;
  assign rs.alu_rs_data = issue_data_q;

  // Stored entries wake from the snooped tags; a dispatching op also sees them (bypass).
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    byp1  = rs.disp_pr1_rdy || (disp_pr1 == 7'd0);
    byp2  = rs.disp_pr2_rdy || (disp_pr2 == 7'd0);
    for (int w = 0; w < NUM_WB; w++) begin
      if (rs.wb_valid[w]) begin
        if (rs.wb_tag[w] == disp_pr1) byp1 = 1'b1;
        if (rs.wb_tag[w] == disp_pr2) byp2 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (rs.wb_tag[w] == ent_pr1[i]) wake1[i] = 1'b1;
          if (rs.wb_tag[w] == ent_pr2[i]) wake2[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = IW'(i);
    end
  end

  assign cand = ent_valid & ent_rdy1 & ent_rdy2;

`ifdef RS_AGE_SELECT_EN
  // age_older[i][j]: entry j was accepted before entry i and is still live.
  logic [DEPTH-1:0] age_older [DEPTH];

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && ((age_older[i] & cand) == '0)) begin
        win       = IW'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rs.flush) begin
      for (int i = 0; i < DEPTH; i++) age_older[i] <= '0;
    end else begin
      if (issue) begin
        for (int i = 0; i < DEPTH; i++) age_older[i][win] <= 1'b0;
      end
      if (accept) begin
        age_older[free_idx] <= ent_valid & ~(issue ? (DEPTH'(1) << win) : '0);
      end
    end
  end
`else
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win       = IW'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  assign issue  = rs.fu_ready && win_found;
  assign accept = rs.disp_valid && rs.disp_ready && !rs.flush;

  always_ff @(posedge clk) begin
    if (reset || rs.flush) begin
      ent_valid    <= '0;
      ent_rdy1     <= '0;
      ent_rdy2     <= '0;
      count        <= '0;
      issued_q     <= 1'b0;
      issue_data_q <= '0;
    end else begin
      ent_rdy1 <= ent_rdy1 | (wake1 & ent_valid);
      ent_rdy2 <= ent_rdy2 | (wake2 & ent_valid);
      if (issue) ent_valid[win] <= 1'b0;
      if (accept) begin
        ent_valid[free_idx] <= 1'b1;
        ent_rdy1[free_idx]  <= byp1;
        ent_rdy2[free_idx]  <= byp2;
        ent_pr1[free_idx]   <= disp_pr1;
        ent_pr2[free_idx]   <= disp_pr2;
        ent_pd[free_idx]    <= disp_pd;
      end
      count        <= count + CW'(accept) - CW'(issue);
      issued_q     <= issue;
      issue_data_q <= issue ? {1'b1, ent_pd[win], ent_pr2[win], ent_pr1[win]} : '0;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus random traffic
// against a slot-level behavioural model (sequence-number ages when RS_AGE_SELECT_EN is set).
module tb_alu_reservation_station;
  localparam int DEPTH  = 8;
  localparam int NUM_WB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) bus ();
  alu_reservation_station #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk  (clk),
    .reset(reset),
    .rs   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: each slot holds an op, its ready flags and acceptance order.
  bit         m_v  [DEPTH];
  bit         m_r1 [DEPTH];
  bit         m_r2 [DEPTH];
  logic [6:0] m_p1 [DEPTH];
  logic [6:0] m_p2 [DEPTH];
  logic [6:0] m_pd [DEPTH];
  int         m_seq[DEPTH];
  int         seq_ctr = 0;
  bit         m_iss;
  logic [21:0] m_data;

  function automatic bit wb_hit(input logic [6:0] t);
    for (int w = 0; w < NUM_WB; w++)
      if (bus.wb_valid[w] && bus.wb_tag[w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic tick();
    int cnt, w, f;
    bit iss, acc;
    cnt = m_count();
    if (!reset) chk("disp_ready", 32'(bus.disp_ready), 32'(cnt < DEPTH));
    if (reset || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      m_iss  = 1'b0;
      m_data = '0;
    end else begin
      w = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SELECT_EN
          if (w < 0 || m_seq[i] < m_seq[w]) w = i;
`else
          if (w < 0) w = i;
`endif
        end
      end
      iss = bus.fu_ready && (w >= 0);
      acc = bus.disp_valid && (cnt < DEPTH);
      f = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_v[i] && f < 0) f = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i]) begin
          if (wb_hit(m_p1[i])) m_r1[i] = 1'b1;
          if (wb_hit(m_p2[i])) m_r2[i] = 1'b1;
        end
      end
      m_iss  = iss;
      m_data = '0;
      if (iss) begin
        m_data = {1'b1, m_pd[w], m_p2[w], m_p1[w]};
        m_v[w] = 1'b0;
      end
      if (acc) begin
        m_v[f]   = 1'b1;
        m_p1[f]  = bus.disp_data[6:0];
        m_p2[f]  = bus.disp_data[13:7];
        m_pd[f]  = bus.disp_data[20:14];
        m_r1[f]  = bus.disp_pr1_rdy || (m_p1[f] == 0) || wb_hit(m_p1[f]);
        m_r2[f]  = bus.disp_pr2_rdy || (m_p2[f] == 0) || wb_hit(m_p2[f]);
        m_seq[f] = seq_ctr++;
      end
    end
    @(posedge clk);
    #1;
    chk("occupancy", 32'(bus.occupancy), 32'(m_count()));
    chk("alu_issued", 32'(bus.alu_issued), 32'(m_iss));
    chk("alu_rs_data", 32'(bus.alu_rs_data), 32'(m_data));
  endtask

  task automatic drive(input bit dv, input int p1, input int p2, input int pd,
                       input bit r1, input bit r2, input bit fu);
    bus.flush        = 1'b0;
    bus.disp_valid   = dv;
    bus.disp_data    = {1'b1, 7'(pd), 7'(p2), 7'(p1)};
    bus.disp_pr1_rdy = r1;
    bus.disp_pr2_rdy = r2;
    bus.fu_ready     = fu;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
  endtask

  task automatic idle(input bit fu);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, fu);
  endtask

  task automatic wake(input int port, input int tag);
    bus.wb_valid[port] = 1'b1;
    bus.wb_tag[port]   = 7'(tag);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b1);
    tick();
    tick();
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_issued", 32'(bus.alu_issued), 32'd0);
    reset = 1'b0;

    // Both sources ready at dispatch: minimum latency.
    drive(1'b1, 5, 6, 10, 1'b1, 1'b1, 1'b1);
    tick();
    chk("t1_occ1", 32'(bus.occupancy), 32'd1);
    idle(1'b1);
    tick();
    chk("t1_issued", 32'(bus.alu_issued), 32'd1);
    chk("t1_data", 32'(bus.alu_rs_data), 32'({1'b1, 7'd10, 7'd6, 7'd5}));
    chk("t1_occ0", 32'(bus.occupancy), 32'd0);

    // Wakeup on port 1 three cycles after dispatch.
    drive(1'b1, 12, 3, 11, 1'b0, 1'b1, 1'b1);
    tick();
    idle(1'b1); tick();
    idle(1'b1); tick();
    idle(1'b1); wake(1, 12); tick();
    chk("t2_not_early", 32'(bus.alu_issued), 32'd0);
    idle(1'b1); tick();
    chk("t2_issued", 32'(bus.alu_issued), 32'd1);
    chk("t2_pd", 32'(bus.alu_rs_data[20:14]), 32'd11);

    // Same-cycle writeback bypass at dispatch.
    drive(1'b1, 20, 21, 12, 1'b0, 1'b1, 1'b1);
    wake(0, 20);
    tick();
    idle(1'b1); tick();
    chk("t3_bypass", 32'(bus.alu_issued), 32'd1);

    // Fill all entries unready, then overflow attempt, then free one.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 40 + i, 1, 30 + i, 1'b0, 1'b1, 1'b1);
      tick();
    end
    chk("t4_full_occ", 32'(bus.occupancy), 32'(DEPTH));
    drive(1'b1, 2, 2, 99, 1'b1, 1'b1, 1'b1);
    chk("t4_full_ready", 32'(bus.disp_ready), 32'd0);
    tick();
    drive(1'b1, 2, 2, 99, 1'b1, 1'b1, 1'b1);
    wake(2, 43);
    tick();
    drive(1'b1, 2, 2, 99, 1'b1, 1'b1, 1'b1);
    tick();
    chk("t4_freed_issue", 32'(bus.alu_rs_data[20:14]), 32'd33);
    chk("t4_ready_back", 32'(bus.disp_ready), 32'd1);
    tick();

    // Age ordering, A in entry 0.
    bus.flush = 1'b1; tick();
    drive(1'b1, 50, 1, 100, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 51, 1, 101, 1'b1, 1'b1, 1'b0); tick();
    idle(1'b0); wake(0, 50); tick();
    idle(1'b1); tick();
    chk("t5_first", 32'(bus.alu_rs_data[20:14]), 32'd100);
    idle(1'b1); tick();

    // Age ordering, A in entry 1 and younger B reusing entry 0.
    bus.flush = 1'b1; tick();
    drive(1'b1, 3, 4, 102, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 52, 1, 100, 1'b0, 1'b1, 1'b0); tick();
    idle(1'b1); tick();
    drive(1'b1, 53, 1, 101, 1'b1, 1'b1, 1'b0); tick();
    idle(1'b0); wake(2, 52); tick();
    idle(1'b1); tick();
`ifdef RS_AGE_SELECT_EN
    chk("t5_reuse_first", 32'(bus.alu_rs_data[20:14]), 32'd100);
`else
    chk("t5_reuse_first", 32'(bus.alu_rs_data[20:14]), 32'd101);
`endif
    idle(1'b1); tick();

    // Flush with four live entries and a dispatch in the same cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 60 + i, 1, 70 + i, 1'b0, 1'b1, 1'b1);
      tick();
    end
    drive(1'b1, 5, 5, 80, 1'b1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    chk("t6_occ", 32'(bus.occupancy), 32'd0);
    chk("t6_issued", 32'(bus.alu_issued), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1); wake(i % NUM_WB, 60 + i); tick();
    end
    idle(1'b1); tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 127), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 63) == 0);
      for (int w = 0; w < NUM_WB; w++) begin
        bus.wb_valid[w] = ($urandom_range(0, 9) < 4);
        bus.wb_tag[w]   = 7'($urandom_range(0, 15));
      end
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
